// File: rtl/mdu_ctrl.sv
// Iterative radix-2 multiply/divide unit with HI/LO registers and a stall handshake.
// Optional macro MDU_EARLY_OUT_EN: multiply finishes as soon as the remaining multiplier bits are zero.
module mdu_ctrl #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Start,
    input  logic [5:0]       Func,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic [WIDTH-1:0] MfData,
    output logic             Busy,
    output logic             Done,
    output logic             Stall
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    localparam logic [5:0] FnMfhi  = 6'd16;
    localparam logic [5:0] FnMthi  = 6'd17;
    localparam logic [5:0] FnMflo  = 6'd18;
    localparam logic [5:0] FnMtlo  = 6'd19;
    localparam logic [5:0] FnMult  = 6'd24;
    localparam logic [5:0] FnMultu = 6'd25;
    localparam logic [5:0] FnDiv   = 6'd26;
    localparam logic [5:0] FnDivu  = 6'd27;

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     opd_q, opd_d;
    logic                 neg_q, neg_d;
    logic                 rneg_q, rneg_d;
    logic                 dz_q, dz_d;
    logic                 div_q, div_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 done_q, done_d;

    logic                 is_group;
    logic                 op_signed;
    logic                 sign_a, sign_b;
    logic [WIDTH-1:0]     a_abs, b_abs;
    logic [CNT_W-1:0]     cnt_next;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       rem_sh;
    logic                 div_ok;
    logic [WIDTH-1:0]     div_diff;
    logic [WIDTH-1:0]     rem_new;
    logic [2*WIDTH-1:0]   div_next;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     rem_raw, quo_raw;
    logic [WIDTH-1:0]     rem_fix, quo_fix;
`ifdef MDU_EARLY_OUT_EN
    logic [WIDTH-1:0]     rem_mask;
`endif

    assign is_group = (Func inside {FnMfhi, FnMthi, FnMflo, FnMtlo,
                                    FnMult, FnMultu, FnDiv, FnDivu});
    assign op_signed = ~Func[0];
    assign sign_a    = op_signed & A[WIDTH-1];
    assign sign_b    = op_signed & B[WIDTH-1];
    assign a_abs     = sign_a ? -A : A;
    assign b_abs     = sign_b ? -B : B;
    assign cnt_next  = cnt_q - CNT_W'(1);

    // Multiply: acc = {partial product, unshifted multiplier}, shifted right each step.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opd_q : '0)};
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Restoring divide: acc = {remainder, dividend/quotient}, shifted left each step.
    assign rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_ok   = (rem_sh >= {1'b0, opd_q});
    assign div_diff = rem_sh[WIDTH-1:0] - opd_q;
    assign rem_new  = div_ok ? div_diff : rem_sh[WIDTH-1:0];
    assign div_next = {rem_new, acc_q[WIDTH-2:0], div_ok};

    assign prod_fix = neg_q ? -acc_q : acc_q;
    assign rem_raw  = acc_q[2*WIDTH-1:WIDTH];
    assign quo_raw  = acc_q[WIDTH-1:0];
    assign rem_fix  = rneg_q ? -rem_raw : rem_raw;
    // Divide by zero leaves |A| as remainder, so the sign fixup restores raw A in Hi.
    assign quo_fix  = dz_q ? '1 : (neg_q ? -quo_raw : quo_raw);

`ifdef MDU_EARLY_OUT_EN
    assign rem_mask = ~({WIDTH{1'b1}} << cnt_next);
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opd_d   = opd_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        div_d   = div_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;

        case (state_q)
            StIdle: begin
                if (Start) begin
                    case (Func)
                        FnMult, FnMultu: begin
                            state_d = StMul;
                            cnt_d   = CNT_W'(WIDTH);
                            acc_d   = {{WIDTH{1'b0}}, b_abs};
                            opd_d   = a_abs;
                            neg_d   = sign_a ^ sign_b;
                            rneg_d  = 1'b0;
                            dz_d    = 1'b0;
                            div_d   = 1'b0;
                        end
                        FnDiv, FnDivu: begin
                            state_d = StDiv;
                            cnt_d   = CNT_W'(WIDTH);
                            acc_d   = {{WIDTH{1'b0}}, a_abs};
                            opd_d   = b_abs;
                            neg_d   = sign_a ^ sign_b;
                            rneg_d  = sign_a;
                            dz_d    = (B == '0);
                            div_d   = 1'b1;
                        end
                        FnMthi: hi_d = A;
                        FnMtlo: lo_d = A;
                        default: ;
                    endcase
                end
            end
            StMul: begin
                cnt_d = cnt_next;
                acc_d = mul_next;
`ifdef MDU_EARLY_OUT_EN
                // No multiplier bits left: finish the pending shifts in one go.
                if ((mul_next[WIDTH-1:0] & rem_mask) == '0) begin
                    acc_d   = mul_next >> cnt_next;
                    state_d = StFix;
                end
`else
                if (cnt_q == CNT_W'(1)) state_d = StFix;
`endif
            end
            StDiv: begin
                cnt_d = cnt_next;
                acc_d = div_next;
                if (cnt_q == CNT_W'(1)) state_d = StFix;
            end
            StFix: begin
                state_d = StIdle;
                done_d  = 1'b1;
                if (div_q) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    {hi_d, lo_d} = prod_fix;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            acc_q   <= '0;
            opd_q   <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            div_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opd_q   <= opd_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
            div_q   <= div_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign Hi     = hi_q;
    assign Lo     = lo_q;
    assign Busy   = (state_q != StIdle);
    assign Done   = done_q;
    assign Stall  = Start & is_group & Busy;
    assign MfData = (Func == FnMfhi) ? hi_q : ((Func == FnMflo) ? lo_q : '0);

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed self-checking bench for mdu_ctrl (WIDTH=32); inputs change and outputs are
// sampled on the falling clock edge.
module tb_mdu_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        Start;
    logic [5:0]  Func;
    logic [31:0] A, B;
    logic [31:0] Hi, Lo, MfData;
    logic        Busy, Done, Stall;

    int checks = 0;
    int errors = 0;

    mdu_ctrl #(.WIDTH(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .Start  (Start),
        .Func   (Func),
        .A      (A),
        .B      (B),
        .Hi     (Hi),
        .Lo     (Lo),
        .MfData (MfData),
        .Busy   (Busy),
        .Done   (Done),
        .Stall  (Stall)
    );

    always #5 clk = ~clk;

    // Called at a falling edge; returns at the falling edge right after the accept edge.
    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        Start = 1'b1;
        Func  = f;
        A     = a;
        B     = b;
        @(posedge clk);
        @(negedge clk);
        Start = 1'b0;
    endtask

    // c = clock edges after accept until Done is seen; nb = cycles with Busy high before that.
    task automatic wait_done(output int c, output int nb);
        c  = 0;
        nb = 0;
        while (Done !== 1'b1 && c < 200) begin
            if (Busy === 1'b1) nb++;
            @(negedge clk);
            c++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        Start = 1'b0;
        Func = 6'd16;
        A = '0;
        B = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checks++;
        if (Hi !== 32'h0 || Lo !== 32'h0) begin
            errors++;
            $display("FAIL reset_hilo: Hi=%h Lo=%h expected 0/0", Hi, Lo);
        end
        checks++;
        if (Busy !== 1'b0 || Done !== 1'b0 || Stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: Busy=%b Done=%b Stall=%b expected 0/0/0", Busy, Done, Stall);
        end
        checks++;
        if (MfData !== 32'h0) begin
            errors++;
            $display("FAIL reset_mfdata: got %h expected 0", MfData);
        end
    endtask

    task automatic test_multu_max;
        int c, nb;
        issue(6'd25, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(c, nb);
        checks++;
        if (c != 33) begin
            errors++;
            $display("FAIL multu_latency: Done after %0d cycles expected 33", c);
        end
        checks++;
        if (nb != 33) begin
            errors++;
            $display("FAIL multu_busy: Busy for %0d cycles expected 33", nb);
        end
        checks++;
        if (Hi !== 32'hFFFF_FFFE || Lo !== 32'h0000_0001) begin
            errors++;
            $display("FAIL multu_max: Hi=%h Lo=%h expected fffffffe/00000001", Hi, Lo);
        end
        @(negedge clk);
        checks++;
        if (Done !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse: Done=%b one cycle later, expected 0", Done);
        end
    endtask

    task automatic test_mult_signed;
        int c, nb;
        issue(6'd24, 32'hFFFF_FFFD, 32'd5);
        wait_done(c, nb);
        checks++;
        if (Hi !== 32'hFFFF_FFFF || Lo !== 32'hFFFF_FFF1) begin
            errors++;
            $display("FAIL mult_neg3x5: Hi=%h Lo=%h expected ffffffff/fffffff1", Hi, Lo);
        end
        @(negedge clk);
        issue(6'd24, 32'hFFFF_FFFC, 32'hFFFF_FFFA);
        wait_done(c, nb);
        checks++;
        if (Hi !== 32'h0 || Lo !== 32'h0000_0018) begin
            errors++;
            $display("FAIL mult_neg4xneg6: Hi=%h Lo=%h expected 00000000/00000018", Hi, Lo);
        end
    endtask

    task automatic test_div;
        int c, nb;
        issue(6'd26, 32'hFFFF_FFF9, 32'd2);
        wait_done(c, nb);
        checks++;
        if (c != 33) begin
            errors++;
            $display("FAIL div_latency: Done after %0d cycles expected 33", c);
        end
        checks++;
        if (Lo !== 32'hFFFF_FFFD || Hi !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL div_neg7by2: Lo=%h Hi=%h expected fffffffd/ffffffff", Lo, Hi);
        end
        @(negedge clk);
        issue(6'd26, 32'd7, 32'hFFFF_FFFE);
        wait_done(c, nb);
        checks++;
        if (Lo !== 32'hFFFF_FFFD || Hi !== 32'h0000_0001) begin
            errors++;
            $display("FAIL div_7byneg2: Lo=%h Hi=%h expected fffffffd/00000001", Lo, Hi);
        end
        @(negedge clk);
        issue(6'd27, 32'hFFFF_FFF9, 32'd2);
        wait_done(c, nb);
        checks++;
        if (Lo !== 32'h7FFF_FFFC || Hi !== 32'h0000_0001) begin
            errors++;
            $display("FAIL divu_big: Lo=%h Hi=%h expected 7ffffffc/00000001", Lo, Hi);
        end
    endtask

    task automatic test_div_zero;
        int c, nb;
        issue(6'd27, 32'd7, 32'd0);
        wait_done(c, nb);
        checks++;
        if (c != 33) begin
            errors++;
            $display("FAIL divz_latency: Done after %0d cycles expected 33", c);
        end
        checks++;
        if (Lo !== 32'hFFFF_FFFF || Hi !== 32'h0000_0007) begin
            errors++;
            $display("FAIL divu_by0: Lo=%h Hi=%h expected ffffffff/00000007", Lo, Hi);
        end
        @(negedge clk);
        issue(6'd26, 32'hFFFF_FFFB, 32'd0);
        wait_done(c, nb);
        checks++;
        if (Lo !== 32'hFFFF_FFFF || Hi !== 32'hFFFF_FFFB) begin
            errors++;
            $display("FAIL div_by0_signed: Lo=%h Hi=%h expected ffffffff/fffffffb", Lo, Hi);
        end
    endtask

    task automatic test_overflow;
        int c, nb;
        issue(6'd26, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(c, nb);
        checks++;
        if (Lo !== 32'h8000_0000 || Hi !== 32'h0) begin
            errors++;
            $display("FAIL div_overflow: Lo=%h Hi=%h expected 80000000/00000000", Lo, Hi);
        end
    endtask

    task automatic test_stall_mf;
        int c, bad;
        issue(6'd25, 32'h0001_0000, 32'h0003_0003);
        Start = 1'b1;
        Func  = 6'd18;
        #1;
        c   = 0;
        bad = 0;
        while (Done !== 1'b1 && c < 200) begin
            if (Stall !== 1'b1) bad++;
            @(negedge clk);
            c++;
        end
        checks++;
        if (bad != 0 || c >= 200) begin
            errors++;
            $display("FAIL mflo_stall: %0d busy cycles without Stall, waited %0d", bad, c);
        end
        checks++;
        if (Stall !== 1'b0 || MfData !== 32'h0003_0000) begin
            errors++;
            $display("FAIL mflo_done: Stall=%b MfData=%h expected 0/00030000", Stall, MfData);
        end
        checks++;
        if (Hi !== 32'h0000_0003) begin
            errors++;
            $display("FAIL multu_hi: Hi=%h expected 00000003", Hi);
        end
        Start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_start_while_busy;
        int c, nb;
        issue(6'd25, 32'd6, 32'd7);
        Start = 1'b1;
        Func  = 6'd19;
        A     = 32'hDEAD;
        #1;
        checks++;
        if (Stall !== 1'b1) begin
            errors++;
            $display("FAIL mtlo_stall: Stall=%b expected 1", Stall);
        end
        @(negedge clk);
        Func = 6'd27;
        A    = 32'd100;
        B    = 32'd7;
        repeat (3) @(negedge clk);
        Start = 1'b0;
        wait_done(c, nb);
        checks++;
        if (Lo !== 32'd42 || Hi !== 32'd0) begin
            errors++;
            $display("FAIL busy_start_ignored: Lo=%h Hi=%h expected 0000002a/00000000", Lo, Hi);
        end
        @(negedge clk);
        checks++;
        if (Busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_after_done: Busy=%b expected 0", Busy);
        end
    endtask

    task automatic test_mt_mf;
        Start = 1'b1;
        Func  = 6'd17;
        A     = 32'h1234;
        #1;
        checks++;
        if (Stall !== 1'b0) begin
            errors++;
            $display("FAIL mthi_nostall: Stall=%b expected 0", Stall);
        end
        @(posedge clk);
        @(negedge clk);
        Func = 6'd19;
        A    = 32'h5678;
        checks++;
        if (Hi !== 32'h1234 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL mthi: Hi=%h Busy=%b expected 00001234/0", Hi, Busy);
        end
        @(posedge clk);
        @(negedge clk);
        Start = 1'b0;
        checks++;
        if (Lo !== 32'h5678 || Hi !== 32'h1234) begin
            errors++;
            $display("FAIL mtlo: Lo=%h Hi=%h expected 00005678/00001234", Lo, Hi);
        end
        Func = 6'd16;
        #1;
        checks++;
        if (MfData !== 32'h1234) begin
            errors++;
            $display("FAIL mfhi_data: got %h expected 00001234", MfData);
        end
        Func = 6'd18;
        #1;
        checks++;
        if (MfData !== 32'h5678) begin
            errors++;
            $display("FAIL mflo_data: got %h expected 00005678", MfData);
        end
        Func = 6'd24;
        #1;
        checks++;
        if (MfData !== 32'h0) begin
            errors++;
            $display("FAIL mf_other: got %h expected 0", MfData);
        end
        // Unlisted function code with Start must leave everything alone.
        Start = 1'b1;
        Func  = 6'd32;
        A     = 32'hAAAA;
        B     = 32'h5;
        @(posedge clk);
        @(negedge clk);
        Start = 1'b0;
        checks++;
        if (Busy !== 1'b0 || Hi !== 32'h1234 || Lo !== 32'h5678) begin
            errors++;
            $display("FAIL unlisted_func: Busy=%b Hi=%h Lo=%h expected 0/00001234/00005678",
                     Busy, Hi, Lo);
        end
    endtask

    task automatic test_back_to_back;
        int c, nb;
        issue(6'd25, 32'd11, 32'd13);
        wait_done(c, nb);
        checks++;
        if (Lo !== 32'd143) begin
            errors++;
            $display("FAIL b2b_first: Lo=%h expected 0000008f", Lo);
        end
        issue(6'd27, 32'd100, 32'd7);
        wait_done(c, nb);
        checks++;
        if (c != 33) begin
            errors++;
            $display("FAIL b2b_latency: Done after %0d cycles expected 33", c);
        end
        checks++;
        if (Lo !== 32'd14 || Hi !== 32'd2) begin
            errors++;
            $display("FAIL b2b_second: Lo=%h Hi=%h expected 0000000e/00000002", Lo, Hi);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int bad;
        issue(6'd26, 32'd1000, 32'd3);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (Hi !== 32'h0 || Lo !== 32'h0 || Busy !== 1'b0 || Done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: Hi=%h Lo=%h Busy=%b Done=%b expected 0/0/0/0",
                     Hi, Lo, Busy, Done);
        end
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (Done !== 1'b0 || Busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_abort: %0d cycles with Done/Busy after reset, expected 0", bad);
        end
    endtask

`ifdef MDU_EARLY_OUT_EN
    task automatic test_early_out;
        int c, nb;
        issue(6'd25, 32'd9, 32'd3);
        wait_done(c, nb);
        checks++;
        if (c != 3) begin
            errors++;
            $display("FAIL early_latency: Done after %0d cycles expected 3", c);
        end
        checks++;
        if (Lo !== 32'd27 || Hi !== 32'd0) begin
            errors++;
            $display("FAIL early_result: Lo=%h Hi=%h expected 0000001b/00000000", Lo, Hi);
        end
        @(negedge clk);
        issue(6'd25, 32'd9, 32'd0);
        wait_done(c, nb);
        checks++;
        if (c != 2 || Lo !== 32'd0 || Hi !== 32'd0) begin
            errors++;
            $display("FAIL early_zero: cycles=%0d Lo=%h Hi=%h expected 2/0/0", c, Lo, Hi);
        end
        @(negedge clk);
    endtask
`endif

    initial begin
        @(negedge clk);
        test_reset();
        test_multu_max();
        test_mult_signed();
        @(negedge clk);
        test_div();
        @(negedge clk);
        test_div_zero();
        @(negedge clk);
        test_overflow();
        @(negedge clk);
        test_stall_mf();
        test_start_while_busy();
        test_mt_mf();
        test_back_to_back();
`ifdef MDU_EARLY_OUT_EN
        test_early_out();
`endif
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, errors);
        $finish;
    end

endmodule
